// File: rtl/sobel_pkg.sv
// Shared constants for the camera capture sequencer:
// FSM encodings, line-buffer rotation and synchronizer depth.
package sobel_pkg;

  localparam logic [2:0] ST_WAIT_FRAME = 3'd0;
  localparam logic [2:0] ST_VBLANK     = 3'd1;
  localparam logic [2:0] ST_WAIT_LINE  = 3'd2;
  localparam logic [2:0] ST_ACTIVE     = 3'd3;
  localparam logic [2:0] ST_LINE_END   = 3'd4;

  localparam logic [1:0] WR_SEL_N = 2'd3;
  localparam int SYNC_DEPTH = 2;

  function automatic logic [1:0] next_wr_sel(
    input logic [1:0] s
  );
    return (s == WR_SEL_N - 2'd1) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Multi-FF synchronizer for one asynchronous camera pin,
// followed by an edge-detect register.
module cam_sync_edge
  import sobel_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_DEPTH-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;

endmodule

// File: rtl/cam_capture_seq.sv
// Camera capture sequencer: keeps Y bytes, tracks col/row/frame,
// rotates line-buffer selects and flags when a 3x3 window exists.
module cam_capture_seq
  import sobel_pkg::*;
#(
  parameter int LINE_W = 10,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 9
) (
  input  logic             clk,
  input  logic             rst_hw,
  input  logic             PCLK,
  input  logic             Href,
  input  logic             VSYNC,
  input  logic [7:0]       in_pixel,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [1:0]       wr_sel,
  output logic             line_done,
  output logic             frame_start,
  output logic             win_ready,
  output logic             err_overrun,
  output logic             err_short
);

  localparam logic [COL_W-1:0] LINE_C = COL_W'(LINE_W);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;

  cam_sync_edge u_pclk (
    .clk_i (clk),
    .rst_i (rst_hw),
    .d_i   (PCLK),
    .lvl_o (pclk_lvl),
    .rise_o(pclk_rise),
    .fall_o(pclk_fall)
  );

  cam_sync_edge u_href (
    .clk_i (clk),
    .rst_i (rst_hw),
    .d_i   (Href),
    .lvl_o (href_lvl),
    .rise_o(href_rise),
    .fall_o(href_fall)
  );

  cam_sync_edge u_vsync (
    .clk_i (clk),
    .rst_i (rst_hw),
    .d_i   (VSYNC),
    .lvl_o (vs_lvl),
    .rise_o(vs_rise),
    .fall_o(vs_fall)
  );

  logic unused_sync;
  assign unused_sync =
    &{1'b0, pclk_lvl, pclk_fall, href_lvl, vs_rise};

  logic [2:0]       state_q, state_d;
  logic [COL_W-1:0] cnt_q, cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       ws_q, ws_d;
  logic             phase_q, phase_d;
  logic [7:0]       byte_q;
  logic [7:0]       pix_q, pix_d;
  logic             pv_q, pv_d;
  logic             ld_q, ld_d;
  logic             fs_q, fs_d;
  logic             win_q, win_d;
  logic             ovr_q, ovr_d;
  logic             sht_q, sht_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    ws_d    = ws_q;
    phase_d = phase_q;
    pix_d   = pix_q;
    pv_d    = 1'b0;
    ld_d    = 1'b0;
    fs_d    = 1'b0;
    win_d   = win_q;
    ovr_d   = ovr_q;
    sht_d   = sht_q;
    unique case (state_q)
      ST_WAIT_FRAME: begin
        if (vs_lvl) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        row_d = '0;
        ws_d  = 2'd0;
        win_d = 1'b0;
        if (vs_fall) begin
          fs_d    = 1'b1;
          ovr_d   = 1'b0;
          sht_d   = 1'b0;
          state_d = ST_WAIT_LINE;
        end
      end
      ST_WAIT_LINE: begin
        if (href_rise) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // pixel on the same clk as Href fall is still taken
        if (pclk_rise) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            if (cnt_q < LINE_C) begin
              pix_d = byte_q;
              pv_d  = 1'b1;
              col_d = cnt_q;
              cnt_d = cnt_q + COL_W'(1);
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        if (href_fall) state_d = ST_LINE_END;
      end
      ST_LINE_END: begin
        ld_d = 1'b1;
        if (cnt_q < LINE_C) sht_d = 1'b1;
        if (row_q != '1) row_d = row_q + ROW_W'(1);
        ws_d = next_wr_sel(ws_q);
        if (row_q == ROW_W'(1)) win_d = 1'b1;
        state_d = ST_WAIT_LINE;
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
    // vertical blank aborts whatever is in flight
    if (vs_lvl) begin
      state_d = ST_VBLANK;
      pv_d    = 1'b0;
      ld_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_hw) begin
      state_q <= ST_WAIT_FRAME;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ws_q    <= 2'd0;
      phase_q <= 1'b0;
      byte_q  <= 8'd0;
      pix_q   <= 8'd0;
      pv_q    <= 1'b0;
      ld_q    <= 1'b0;
      fs_q    <= 1'b0;
      win_q   <= 1'b0;
      ovr_q   <= 1'b0;
      sht_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ws_q    <= ws_d;
      phase_q <= phase_d;
      byte_q  <= in_pixel;
      pix_q   <= pix_d;
      pv_q    <= pv_d;
      ld_q    <= ld_d;
      fs_q    <= fs_d;
      win_q   <= win_d;
      ovr_q   <= ovr_d;
      sht_q   <= sht_d;
    end
  end

  assign pix_data    = pix_q;
  assign pix_valid   = pv_q;
  assign col         = col_q;
  assign row         = row_q;
  assign wr_sel      = ws_q;
  assign line_done   = ld_q;
  assign frame_start = fs_q;
  assign win_ready   = win_q;
  assign err_overrun = ovr_q;
  assign err_short   = sht_q;

endmodule

// File: tb/tb_cam_capture_seq.sv
// Scoreboard bench for cam_capture_seq: directed camera
// waveforms, expected strobes queued and checked by a monitor.
module tb_cam_capture_seq;

  localparam int LINE_W = 10;
  localparam int COL_W  = 9;
  localparam int ROW_W  = 9;

  localparam int K_PIX = 0;
  localparam int K_LD  = 1;
  localparam int K_FS  = 2;

  logic             clk = 1'b0;
  logic             rst_hw = 1'b1;
  logic             PCLK = 1'b0;
  logic             Href = 1'b0;
  logic             VSYNC = 1'b0;
  logic [7:0]       in_pixel = 8'd0;
  logic [7:0]       pix_data;
  logic             pix_valid;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [1:0]       wr_sel;
  logic             line_done;
  logic             frame_start;
  logic             win_ready;
  logic             err_overrun;
  logic             err_short;

  cam_capture_seq #(
    .LINE_W(LINE_W),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) dut (
    .clk        (clk),
    .rst_hw     (rst_hw),
    .PCLK       (PCLK),
    .Href       (Href),
    .VSYNC      (VSYNC),
    .in_pixel   (in_pixel),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .col        (col),
    .row        (row),
    .wr_sel     (wr_sel),
    .line_done  (line_done),
    .frame_start(frame_start),
    .win_ready  (win_ready),
    .err_overrun(err_overrun),
    .err_short  (err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int data;
    int col;
    int ws;
    int row;
    bit win;
    bit ovr;
    bit sht;
  } ev_t;

  ev_t exp_q[$];
  int  total  = 0;
  int  passed = 0;

  int exp_row = 0;
  int exp_ws  = 0;
  bit exp_win = 0;
  bit exp_ovr = 0;
  bit exp_sht = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  function automatic logic [63:0] status_vec();
    return {49'd0, row, wr_sel, win_ready,
            err_overrun, err_short};
  endfunction

  function automatic logic [63:0] all_outs();
    return {18'd0, pix_data, pix_valid, col, row, wr_sel,
            line_done, frame_start, win_ready,
            err_overrun, err_short};
  endfunction

  always @(negedge clk) begin
    if (!rst_hw && (pix_valid || line_done || frame_start)) begin
      logic [63:0] got, want;
      ev_t e;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: pv=%0b ld=%0b fs=%0b want none",
                 pix_valid, line_done, frame_start);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == K_PIX) begin
          got  = {43'd0, pix_valid, line_done, frame_start,
                  pix_data, col, wr_sel};
          want = {43'd0, 3'b100, e.data[7:0],
                  e.col[COL_W-1:0], e.ws[1:0]};
          chk("pixel", got, want);
        end else begin
          got  = {46'd0, pix_valid, line_done, frame_start,
                  row, wr_sel, win_ready, err_overrun, err_short};
          want = {46'd0, (e.kind == K_LD) ? 3'b010 : 3'b001,
                  e.row[ROW_W-1:0], e.ws[1:0],
                  e.win, e.ovr, e.sht};
          chk((e.kind == K_LD) ? "line_done" : "frame_start",
              got, want);
        end
      end
    end
  end

  task automatic push_pix(input int d, input int c);
    ev_t e;
    e = '{K_PIX, d, c, exp_ws, 0, 1'b0, 1'b0, 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic cam_byte(input int b);
    in_pixel = b[7:0];
    PCLK = 1'b0;
    #40;
    PCLK = 1'b1;
    #40;
    PCLK = 1'b0;
  endtask

  task automatic drive_pairs(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      cam_byte(base + i);
      cam_byte(base + i);
    end
  endtask

  task automatic raw_line(input int n, input int base);
    Href = 1'b1;
    #80;
    drive_pairs(n, base);
    Href = 1'b0;
    #120;
  endtask

  task automatic send_line(input int n, input int base);
    ev_t e;
    for (int i = 0; i < n && i < LINE_W; i++)
      push_pix(base + i, i);
    if (n > LINE_W) exp_ovr = 1'b1;
    if (n < LINE_W) exp_sht = 1'b1;
    if (exp_row < (1 << ROW_W) - 1) exp_row++;
    exp_ws = (exp_ws + 1) % 3;
    if (exp_row == 2) exp_win = 1'b1;
    e = '{K_LD, 0, 0, exp_ws, exp_row,
          exp_win, exp_ovr, exp_sht};
    exp_q.push_back(e);
    raw_line(n, base);
  endtask

  task automatic model_blank();
    exp_row = 0;
    exp_ws  = 0;
    exp_win = 1'b0;
    exp_ovr = 1'b0;
    exp_sht = 1'b0;
  endtask

  task automatic vsync_fall();
    ev_t e;
    model_blank();
    e = '{K_FS, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    exp_q.push_back(e);
    VSYNC = 1'b0;
    #120;
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    #200;
    vsync_fall();
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk);
    #1 rst_hw = 1'b0;

    // Href activity before any VSYNC is ignored
    raw_line(10, 100);
    raw_line(4, 120);
    @(negedge clk);
    chk("pre_vsync_idle", all_outs(), 64'd0);

    // single line
    vsync_pulse();
    send_line(10, 0);
    @(negedge clk);
    chk("one_line_status", status_vec(),
        {49'd0, 9'd1, 2'd1, 1'b0, 1'b0, 1'b0});

    // three lines: win_ready at second, row=3
    vsync_pulse();
    send_line(10, 0);
    send_line(10, 10);
    send_line(10, 20);
    @(negedge clk);
    chk("three_lines_status", status_vec(),
        {49'd0, 9'd3, 2'd0, 1'b1, 1'b0, 1'b0});

    // overrun then short line
    vsync_pulse();
    send_line(12, 50);
    send_line(8, 70);
    @(negedge clk);
    chk("err_flags_set", status_vec(),
        {49'd0, 9'd2, 2'd2, 1'b1, 1'b1, 1'b1});

    // VSYNC mid-line after 5 pixels
    for (int i = 0; i < 5; i++) push_pix(200 + i, i);
    Href = 1'b1;
    #80;
    drive_pairs(5, 200);
    VSYNC = 1'b1;
    #100;
    Href = 1'b0;
    #100;
    @(negedge clk);
    chk("abort_row", {55'd0, row}, 64'd0);
    chk("abort_win", {63'd0, win_ready}, 64'd0);
    vsync_fall();
    @(negedge clk);
    chk("errs_cleared", {62'd0, err_overrun, err_short}, 64'd0);
    send_line(10, 30);

    // reset mid-line
    vsync_pulse();
    for (int i = 0; i < 3; i++) push_pix(150 + i, i);
    Href = 1'b1;
    #80;
    drive_pairs(3, 150);
    @(posedge clk);
    #1 rst_hw = 1'b1;
    @(posedge clk);
    #1 rst_hw = 1'b0;
    @(negedge clk);
    chk("midline_reset", all_outs(), 64'd0);
    model_blank();
    drive_pairs(2, 153);
    Href = 1'b0;
    #120;
    raw_line(10, 160);
    @(negedge clk);
    chk("post_reset_idle", all_outs(), 64'd0);
    vsync_pulse();
    send_line(10, 60);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
